// File: rtl/median_filter_pkg.sv
// Shared encodings for the streaming 3x3 rank filter: per-frame mode, control FSM states, sorter depth.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package median_filter_pkg;

  // Registered stages inside rank9_sort; the top delays its sideband by the same amount.
  localparam int SORT_LAT = 3;

  typedef enum logic [1:0] {
    MODE_BYPASS = 2'b00,
    MODE_MEDIAN = 2'b01,
    MODE_MIN    = 2'b10,
    MODE_MAX    = 2'b11
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2
  } state_e;

endpackage

// File: rtl/median_filter_stream_rank9_sort.sv
// Min / median / max of nine unsigned pixels (row-sort, then column reduction, then a final median of three).
// Latency: 3 enabled stages; a result leaves 3 en-cycles after its inputs are sampled.
// Backpressure: every stage holds while en=0, so a stalled consumer freezes the whole sorter.
// Ports: clk, rst (async active-low), en (shared advance), pix[9] in, min_pix/med_pix/max_pix out.
module rank9_sort #(
  parameter int PIX_W = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic [8:0][PIX_W-1:0] pix,
  output logic [PIX_W-1:0]      min_pix,
  output logic [PIX_W-1:0]      med_pix,
  output logic [PIX_W-1:0]      max_pix
);

  typedef struct packed {
    logic [PIX_W-1:0] hi;
    logic [PIX_W-1:0] mid;
    logic [PIX_W-1:0] lo;
  } tri_t;

  function automatic tri_t sort3(input logic [PIX_W-1:0] a, input logic [PIX_W-1:0] b,
                                 input logic [PIX_W-1:0] c);
    tri_t             r;
    logic [PIX_W-1:0] l1;
    logic [PIX_W-1:0] h1;
    l1 = (a < b) ? a : b;
    h1 = (a < b) ? b : a;
    if (c < l1) begin
      r.lo = c;  r.mid = l1; r.hi = h1;
    end else if (c < h1) begin
      r.lo = l1; r.mid = c;  r.hi = h1;
    end else begin
      r.lo = l1; r.mid = h1; r.hi = c;
    end
    return r;
  endfunction

  tri_t             s1_row [3];
  logic [PIX_W-1:0] s2_max_lo, s2_med_mid, s2_min_hi, s2_min, s2_max;
  tri_t             t_lo, t_mid, t_hi, t_fin;

  // Stage-2 reductions over the three sorted rows.
  always_comb begin
    t_lo  = sort3(s1_row[0].lo,  s1_row[1].lo,  s1_row[2].lo);
    t_mid = sort3(s1_row[0].mid, s1_row[1].mid, s1_row[2].mid);
    t_hi  = sort3(s1_row[0].hi,  s1_row[1].hi,  s1_row[2].hi);
    // Median of nine = median of {max of row-mins, median of row-medians, min of row-maxes}.
    t_fin = sort3(s2_max_lo, s2_med_mid, s2_min_hi);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 3; i++) s1_row[i] <= '0;
      s2_max_lo  <= '0;
      s2_med_mid <= '0;
      s2_min_hi  <= '0;
      s2_min     <= '0;
      s2_max     <= '0;
      min_pix    <= '0;
      med_pix    <= '0;
      max_pix    <= '0;
    end else if (en) begin
      for (int i = 0; i < 3; i++) s1_row[i] <= sort3(pix[3*i], pix[3*i+1], pix[3*i+2]);
      s2_max_lo  <= t_lo.hi;
      s2_med_mid <= t_mid.mid;
      s2_min_hi  <= t_hi.lo;
      s2_min     <= t_lo.lo;
      s2_max     <= t_hi.hi;
      min_pix    <= s2_min;
      med_pix    <= t_fin.mid;
      max_pix    <= s2_max;
    end
  end

endmodule

// File: rtl/median_filter_stream.sv
// Streaming 3x3 rank filter (bypass/median/min/max per frame) with two line buffers and self-flush at end of frame.
// Latency: output pixel p becomes valid SORT_LAT+1 advance cycles after input slot p+IMG_W+1 is taken.
// Backpressure: whole pipeline advances only when !out_valid | out_ready; in_ready follows that, low while flushing.
// Ports: clk, rst (async active-low), cfg_mode, in_data/in_sof/in_valid/in_ready,
//        out_data/out_sof/out_eol/out_valid/out_ready, frame_done (pulse), sof_err (sticky).
module median_filter_stream #(
  parameter int PIX_W    = 8,
  parameter int IMG_W    = 1080,
  parameter int IMG_H    = 1080,
  parameter int SORT_LAT = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       cfg_mode,
  input  logic [PIX_W-1:0] in_data,
  input  logic             in_sof,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [PIX_W-1:0] out_data,
  output logic             out_sof,
  output logic             out_eol,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             frame_done,
  output logic             sof_err
);
  import median_filter_pkg::*;

  localparam int CW  = $clog2(IMG_W);
  localparam int RW  = $clog2(IMG_H + 1);
  localparam int PRW = $clog2(IMG_H);
  localparam int LW  = $clog2(IMG_W + 2);

  state_e           state_q, state_d;
  mode_e            frame_mode;
  logic             rst_done;
  logic             adv, rdy, acc, slot_go, dummy;
  logic [PIX_W-1:0] slot_dat;

  logic [CW-1:0]    in_col;      // line-buffer pointer; keeps wrapping through the dummy slots
  logic [RW-1:0]    in_row;
  logic [LW-1:0]    lead_cnt;    // saturates at IMG_W+1: from then on every slot completes a window
  logic [LW-1:0]    dum_cnt;
  logic [CW-1:0]    p_col;       // position of the pixel whose window was just formed
  logic [PRW-1:0]   p_row;
  logic [CW-1:0]    o_col;       // position of the beat currently on the output
  logic [PRW-1:0]   o_row;
  logic             last_in, last_acc, fill, dum_left, bdr_now;

  logic [PIX_W-1:0] lb_a [IMG_W];
  logic [PIX_W-1:0] lb_b [IMG_W];
  logic [PIX_W-1:0] lb_a_rd, lb_b_rd;

  logic [2:0][2:0][PIX_W-1:0] win;   // [row][col], row 0 = oldest line, col 2 = newest column
  logic [8:0][PIX_W-1:0]      win_flat;
  logic                       win_vld, win_bdr;

  logic [SORT_LAT-1:0]            sb_vld, sb_bdr;
  logic [SORT_LAT-1:0][PIX_W-1:0] sb_ctr;
  logic [PIX_W-1:0]               min_pix, med_pix, max_pix, res;

  assign adv      = !out_valid || out_ready;
  assign in_ready = rdy;
  assign last_in  = (in_row == RW'(IMG_H - 1)) && (in_col == CW'(IMG_W - 1));
  assign last_acc = out_valid && out_ready && (o_row == PRW'(IMG_H - 1)) && (o_col == CW'(IMG_W - 1));
  assign fill     = (lead_cnt == LW'(IMG_W + 1));
  assign dum_left = (dum_cnt != LW'(IMG_W + 1));
  assign bdr_now  = (p_row == '0) || (p_row == PRW'(IMG_H - 1)) || (p_col == '0) || (p_col == CW'(IMG_W - 1));
  assign slot_dat = dummy ? '0 : in_data;
  assign lb_a_rd  = lb_a[in_col];
  assign lb_b_rd  = lb_b[in_col];
  assign win_flat = win;

  // ---------------- control FSM ----------------
  always_comb begin
    state_d = state_q;
    rdy     = 1'b0;
    acc     = 1'b0;
    slot_go = 1'b0;
    dummy   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        rdy = rst_done && adv;
        acc = in_valid && rdy;
        if (acc && in_sof) begin
          slot_go = 1'b1;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        rdy = adv;
        acc = in_valid && rdy;
        if (acc) begin
          slot_go = 1'b1;
          if (last_in) state_d = ST_FLUSH;
        end
      end
      ST_FLUSH: begin
        if (adv && dum_left) begin
          slot_go = 1'b1;
          dummy   = 1'b1;
        end
        if (last_acc) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      rst_done   <= 1'b0;
      frame_mode <= MODE_BYPASS;
      sof_err    <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      state_q    <= state_d;
      rst_done   <= 1'b1;
      frame_done <= (state_q == ST_FLUSH) && last_acc;
      if (state_q == ST_IDLE && slot_go) frame_mode <= mode_e'(cfg_mode);
      if (state_q == ST_RUN && acc && in_sof) sof_err <= 1'b1;
    end
  end

  // ---------------- frame counters ----------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      in_col   <= '0;
      in_row   <= '0;
      lead_cnt <= '0;
      dum_cnt  <= '0;
      p_col    <= '0;
      p_row    <= '0;
    end else if (state_q == ST_FLUSH && last_acc) begin
      in_col   <= '0;
      in_row   <= '0;
      lead_cnt <= '0;
      dum_cnt  <= '0;
      p_col    <= '0;
      p_row    <= '0;
    end else if (slot_go) begin
      in_col <= (in_col == CW'(IMG_W - 1)) ? '0 : in_col + 1'b1;
      if (!dummy && in_col == CW'(IMG_W - 1)) in_row <= in_row + 1'b1;
      if (!fill) lead_cnt <= lead_cnt + 1'b1;
      if (dummy) dum_cnt <= dum_cnt + 1'b1;
      if (fill) begin
        if (p_col == CW'(IMG_W - 1)) begin
          p_col <= '0;
          p_row <= (p_row == PRW'(IMG_H - 1)) ? '0 : p_row + 1'b1;
        end else begin
          p_col <= p_col + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      o_col <= '0;
      o_row <= '0;
    end else if (out_valid && out_ready) begin
      if (o_col == CW'(IMG_W - 1)) begin
        o_col <= '0;
        o_row <= (o_row == PRW'(IMG_H - 1)) ? '0 : o_row + 1'b1;
      end else begin
        o_col <= o_col + 1'b1;
      end
    end
  end

  // ---------------- line buffers and window ----------------
  // Data storage needs no reset: everything read before it is rewritten lands on a masked border.
  always_ff @(posedge clk) begin
    if (slot_go) begin
      lb_a[in_col] <= slot_dat;
      lb_b[in_col] <= lb_a_rd;
      for (int r = 0; r < 3; r++) begin
        win[r][0] <= win[r][1];
        win[r][1] <= win[r][2];
      end
      win[0][2] <= lb_b_rd;
      win[1][2] <= lb_a_rd;
      win[2][2] <= slot_dat;
    end
  end

  // After slot s shifts in, the window centre is pixel s-IMG_W-1.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      win_vld <= 1'b0;
      win_bdr <= 1'b0;
      sb_vld  <= '0;
      sb_bdr  <= '0;
      sb_ctr  <= '0;
    end else if (adv) begin
      win_vld <= slot_go && fill;
      win_bdr <= bdr_now;
      sb_vld  <= {sb_vld[SORT_LAT-2:0], win_vld};
      sb_bdr  <= {sb_bdr[SORT_LAT-2:0], win_bdr};
      sb_ctr  <= {sb_ctr[SORT_LAT-2:0], win[1][1]};
    end
  end

  rank9_sort #(.PIX_W(PIX_W)) u_sort (
    .clk     (clk),
    .rst     (rst),
    .en      (adv),
    .pix     (win_flat),
    .min_pix (min_pix),
    .med_pix (med_pix),
    .max_pix (max_pix)
  );

  // ---------------- mode mux and output register ----------------
  always_comb begin
    res = sb_ctr[SORT_LAT-1];
    if (!sb_bdr[SORT_LAT-1]) begin
      case (frame_mode)
        MODE_MEDIAN: res = med_pix;
        MODE_MIN:    res = min_pix;
        MODE_MAX:    res = max_pix;
        default:     res = sb_ctr[SORT_LAT-1];
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (adv) begin
      out_valid <= sb_vld[SORT_LAT-1];
      if (sb_vld[SORT_LAT-1]) out_data <= res;
    end
  end

  assign out_sof = out_valid && (o_row == '0) && (o_col == '0);
  assign out_eol = out_valid && (o_col == CW'(IMG_W - 1));

endmodule

// File: tb/tb_median_filter_stream.sv
module tb_median_filter_stream;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [1:0] cfg_mode = 2'b00;
  logic [7:0] in_data = '0;
  logic       in_sof = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] out_data;
  logic       out_sof, out_eol, out_valid;
  logic       out_ready = 1'b1;
  logic       frame_done, sof_err;

  median_filter_stream #(.PIX_W(8), .IMG_W(5), .IMG_H(5), .SORT_LAT(3)) dut (
    .clk(clk), .rst(rst), .cfg_mode(cfg_mode),
    .in_data(in_data), .in_sof(in_sof), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_sof(out_sof), .out_eol(out_eol), .out_valid(out_valid),
    .out_ready(out_ready), .frame_done(frame_done), .sof_err(sof_err)
  );

  always #5 clk = ~clk;

  int         chk_cnt = 0;
  int         pass_cnt = 0;
  int         done_cnt = 0;
  int         done_exp = 0;
  logic [9:0] exp_q[$];          // {data, sof, eol}
  logic [7:0] img [25];
  bit         rdy_slow = 1'b0;
  int         cyc = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h, want %0h (t=%0t)", name, act, exp, $time);
  endtask

  function automatic bit is_border(input int i);
    return (i / 5 == 0) || (i / 5 == 4) || (i % 5 == 0) || (i % 5 == 4);
  endfunction

  task automatic push_exp(input logic [7:0] d, input int i);
    exp_q.push_back({d, (i == 0), (i % 5 == 4)});
  endtask

  // out_ready: always high, or high one cycle in three.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      out_ready = rdy_slow ? (cyc % 3 == 0) : 1'b1;
    end
  end

  // Monitor: compares every accepted beat against the scoreboard and checks hold during stalls.
  initial begin
    bit         stalled = 1'b0;
    logic [9:0] held = '0;
    logic [9:0] act;
    forever begin
      @(negedge clk);
      if (frame_done) done_cnt++;
      act = {out_data, out_sof, out_eol};
      if (!rst) begin
        stalled = 1'b0;
      end else if (out_valid) begin
        if (stalled) check("stall_hold", 32'(act), 32'(held));
        if (out_ready) begin
          check("beat_expected", 32'(exp_q.size() != 0), 32'd1);
          if (exp_q.size() != 0) check("out_beat", 32'(act), 32'(exp_q.pop_front()));
          stalled = 1'b0;
        end else begin
          stalled = 1'b1;
          held    = act;
        end
      end
    end
  end

  task automatic drive_beat(input logic [7:0] d, input logic sof);
    bit ok = 1'b0;
    in_data  = d;
    in_sof   = sof;
    in_valid = 1'b1;
    for (int n = 0; n < 1000 && !ok; n++) begin
      @(negedge clk);
      ok = in_ready;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    in_sof   = 1'b0;
    if (!ok) check("in_ready_timeout", 32'd0, 32'd1);
  endtask

  task automatic run_frame(input logic [1:0] mode, input int max_gap, input int sof2);
    cfg_mode = mode;
    for (int i = 0; i < 25; i++) begin
      drive_beat(img[i], (i == 0) || (i == sof2));
      if (i == 0) cfg_mode = ~mode;   // mode must be taken from the SOF beat only
      if (max_gap > 0) repeat ($urandom_range(max_gap, 0)) begin @(posedge clk); #1; end
    end
  endtask

  task automatic wait_done();
    done_exp++;
    for (int n = 0; n < 3000 && done_cnt < done_exp; n++) @(negedge clk);
    check("frame_done_cnt", 32'(done_cnt), 32'(done_exp));
    check("all_beats_out", 32'(exp_q.size()), 32'd0);
    repeat (4) @(negedge clk);
    check("frame_done_once", 32'(done_cnt), 32'(done_exp));
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset state
    repeat (3) @(negedge clk);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_out_data", 32'(out_data), 32'd0);
    check("rst_out_sof", 32'(out_sof), 32'd0);
    check("rst_out_eol", 32'(out_eol), 32'd0);
    check("rst_frame_done", 32'(frame_done), 32'd0);
    check("rst_sof_err", 32'(sof_err), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    repeat (2) begin @(posedge clk); #1; end

    // 1: median, single 255 in the interior is removed
    for (int i = 0; i < 25; i++) begin img[i] = (i == 12) ? 8'd255 : 8'd0; push_exp(8'd0, i); end
    run_frame(2'b01, 0, -1);
    wait_done();

    // 2: median, 255 on the border passes through unchanged
    for (int i = 0; i < 25; i++) begin
      img[i] = (i == 3 || i == 19) ? 8'd255 : 8'd0;
      push_exp(img[i], i);
    end
    run_frame(2'b01, 0, -1);
    wait_done();

    // 3: min then max over a ramp
    for (int i = 0; i < 25; i++) begin
      img[i] = 8'(i);
      push_exp(is_border(i) ? 8'(i) : 8'(i - 6), i);
    end
    run_frame(2'b10, 0, -1);
    wait_done();
    for (int i = 0; i < 25; i++) push_exp(is_border(i) ? 8'(i) : 8'(i + 6), i);
    run_frame(2'b11, 0, -1);
    wait_done();

    // 4: bypass with downstream stalls and input gaps
    rdy_slow = 1'b1;
    for (int i = 0; i < 25; i++) push_exp(8'(i), i);
    run_frame(2'b00, 2, -1);
    wait_done();
    rdy_slow = 1'b0;
    check("sof_err_clean", 32'(sof_err), 32'd0);

    // 5: pre-SOF beats discarded, stray SOF mid-frame flagged
    for (int i = 0; i < 3; i++) drive_beat(8'd99, 1'b0);
    for (int i = 0; i < 25; i++) push_exp(8'(i), i);
    run_frame(2'b00, 0, 7);
    wait_done();
    check("sof_err_set", 32'(sof_err), 32'd1);

    // 6: reset in the middle of a frame, then a clean frame
    for (int i = 0; i < 25; i++) push_exp(8'd200, i);
    cfg_mode = 2'b01;
    for (int i = 0; i < 12; i++) drive_beat(8'd200, i == 0);
    rst = 1'b0;
    exp_q.delete();
    repeat (3) @(negedge clk);
    check("mid_rst_out_valid", 32'(out_valid), 32'd0);
    check("mid_rst_in_ready", 32'(in_ready), 32'd0);
    check("mid_rst_out_data", 32'(out_data), 32'd0);
    check("mid_rst_sof_err", 32'(sof_err), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    repeat (2) begin @(posedge clk); #1; end
    drive_beat(8'd77, 1'b0);
    for (int i = 0; i < 25; i++) begin
      img[i] = 8'(i);
      push_exp(is_border(i) ? 8'(i) : 8'(i - 6), i);
    end
    run_frame(2'b10, 0, -1);
    wait_done();

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
